// File: rtl/share_splitter_pkg.sv
// Shared types and derived constants for the Boolean share splitter.
// Imported by the splitter top and its interface users.
package share_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        MASK,
        OUT
    } state_t;

    // Number of PRNG beats needed to fill the SHARES-1 random words.
    function automatic int unsigned beats_f(input int unsigned shares,
                                            input int unsigned width,
                                            input int unsigned rnd_w);
        return ((shares - 1) * width) / rnd_w;
    endfunction

    function automatic int unsigned cnt_w_f(input int unsigned beats);
        return (beats < 1) ? 1 : $clog2(beats + 1);
    endfunction

    function automatic bit cfg_legal(input int unsigned shares,
                                     input int unsigned width,
                                     input int unsigned rnd_w);
        return (shares >= 2) && (width >= 1) && (rnd_w >= 1) &&
               ((((shares - 1) * width) % rnd_w) == 0);
    endfunction

endpackage

// File: rtl/share_splitter_if.sv
// Handshake bundle of the share splitter: unmasked word in, PRNG beats in,
// masked shares out. The splitter itself uses the slave modport.
interface share_splitter_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned SHARES = 3,
    parameter int unsigned RND_W  = 16
);
    logic [WIDTH-1:0]        in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [RND_W-1:0]        rnd;
    logic                    rnd_valid;
    logic                    rnd_ready;
    logic [SHARES*WIDTH-1:0] out_shares;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ready, out_shares, out_valid
    );

    modport slave (
        input  in_data, in_valid, rnd, rnd_valid, out_ready,
        output in_ready, rnd_ready, out_shares, out_valid
    );
endinterface

// File: rtl/share_splitter_xor_fold.sv
// Bitwise XOR of N packed WIDTH-bit words. Purely combinational; callers
// must only sample its result into a register.
module share_xor_fold #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N     = 3
) (
    input  logic [N*WIDTH-1:0] words,
    output logic [WIDTH-1:0]   fold
);
    always_comb begin
        fold = '0;
        for (int unsigned i = 0; i < N; i++) begin
            fold = fold ^ words[i*WIDTH +: WIDTH];
        end
    end
endmodule

// File: rtl/share_splitter.sv
// Masking encoder: splits one unmasked word into SHARES Boolean shares using
// fresh PRNG beats; every output is driven straight from a register.
module share_splitter
    import share_splitter_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned SHARES = 3,
    parameter int unsigned RND_W  = 16
) (
    input logic            clk,
    input logic            rst,
    share_splitter_if.slave bus
);
    localparam int unsigned BEATS = beats_f(SHARES, WIDTH, RND_W);
    localparam int unsigned CNT_W = cnt_w_f(BEATS);
    localparam int unsigned RND_BITS = (SHARES - 1) * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    generate
        if (!cfg_legal(SHARES, WIDTH, RND_W)) begin : g_cfg_check
            $error("share_splitter: SHARES must be >= 2 and (SHARES-1)*WIDTH a multiple of RND_W");
        end
    endgenerate

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [WIDTH-1:0]        data_r;
    logic [RND_BITS-1:0]     rnd_buf;
    logic [SHARES*WIDTH-1:0] out_shares_q;
    logic                    in_ready_q;
    logic                    rnd_ready_q;
    logic                    out_valid_q;
    logic                    in_ready_d;
    logic                    rnd_ready_d;
    logic                    out_valid_d;
    logic [WIDTH-1:0]        fold_out;

    logic in_fire;
    logic rnd_fire;
    logic last_beat;
    logic out_fire;

    assign in_fire   = (state_q == IDLE) && in_ready_q && bus.in_valid;
    assign rnd_fire  = (state_q == COLLECT) && rnd_ready_q && bus.rnd_valid;
    assign last_beat = rnd_fire && (cnt_q == LAST_CNT);
    assign out_fire  = (state_q == OUT) && out_valid_q && bus.out_ready;

    // Fold operands are the latched word and random words, both registers.
    share_xor_fold #(
        .WIDTH (WIDTH),
        .N     (SHARES)
    ) u_fold (
        .words ({rnd_buf, data_r}),
        .fold  (fold_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs are registered from the next state, so they are
    // already valid in the first cycle of each state.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b0;
        rnd_ready_d = 1'b0;
        out_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_fire) state_d = COLLECT;
            end
            COLLECT: begin
                if (last_beat) state_d = MASK;
            end
            MASK: begin
                state_d = OUT;
            end
            OUT: begin
                if (out_fire) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        rnd_ready_d = (state_d == COLLECT);
        out_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b0;
            rnd_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            rnd_ready_q <= rnd_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            data_r       <= '0;
            rnd_buf      <= '0;
            out_shares_q <= '0;
        end else begin
            if (in_fire) begin
                data_r <= bus.in_data;
                cnt_q  <= '0;
            end
            if (rnd_fire) begin
                for (int unsigned b = 0; b < BEATS; b++) begin
                    if (cnt_q == CNT_W'(b)) begin
                        rnd_buf[b*RND_W +: RND_W] <= bus.rnd;
                    end
                end
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == MASK) begin
                out_shares_q <= {fold_out, rnd_buf};
            end
            if (out_fire) begin
                out_shares_q <= '0;
                data_r       <= '0;
                rnd_buf      <= '0;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.rnd_ready  = rnd_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_shares = out_shares_q;

endmodule

// File: tb/tb_share_splitter.sv
// Directed bench for share_splitter with WIDTH=8, SHARES=3, RND_W=8 (two beats
// per word); expected shares are hand-derived XOR splits.
module tb_share_splitter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   beats_taken;

    share_splitter_if #(.WIDTH(8), .SHARES(3), .RND_W(8)) bus ();

    share_splitter #(
        .WIDTH  (8),
        .SHARES (3),
        .RND_W  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rnd_valid && bus.rnd_ready) beats_taken++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word through the block; cyc counts cycles after the acceptance cycle.
    task automatic run_word(input string tag, input logic [7:0] d, input logic [7:0] b0,
                            input logic [7:0] b1, input int stall, input int hold,
                            input int exp_cyc, input bit rnd_always);
        int          cyc;
        int          waited;
        int          beats0;
        logic [23:0] exp;
        logic [7:0]  recomb;
        exp = {d ^ b0 ^ b1, b1, b0};
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        beats0        = beats_taken;
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        bus.rnd       = b0;
        bus.rnd_valid = rnd_always;
        tick();
        cyc = 1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'hEE;
        bus.rnd       = b0;
        bus.rnd_valid = 1'b1;
        tick();
        cyc++;
        if (stall > 0) begin
            bus.rnd_valid = 1'b0;
            bus.rnd       = 8'h5A;
            for (int i = 0; i < stall; i++) begin
                check({tag, "_stall_rnd_ready"}, 64'(bus.rnd_ready), 64'd1);
                tick();
                cyc++;
            end
        end
        bus.rnd       = b1;
        bus.rnd_valid = 1'b1;
        tick();
        cyc++;
        bus.rnd       = 8'hC3;
        bus.rnd_valid = rnd_always;
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_shares"}, 64'(bus.out_shares), 64'(exp));
        recomb = bus.out_shares[7:0] ^ bus.out_shares[15:8] ^ bus.out_shares[23:16];
        check({tag, "_recombine"}, 64'(recomb), 64'(d));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_shares"}, 64'(bus.out_shares), 64'(exp));
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, "_hold_rnd_ready"}, 64'(bus.rnd_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_post_shares"}, 64'(bus.out_shares), 64'd0);
        check({tag, "_post_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_beats_used"}, 64'(beats_taken - beats0), 64'd2);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b0;
        logic [7:0] b1;
        n_checks      = 0;
        n_fail        = 0;
        beats_taken   = 0;
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.rnd       = '0;
        bus.rnd_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check("reset_rnd_ready", 64'(bus.rnd_ready), 64'd0);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_shares", 64'(bus.out_shares), 64'd0);
        rst = 1'b0;
        tick();
        check("after_reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("after_reset_rnd_ready", 64'(bus.rnd_ready), 64'd0);

        run_word("basic", 8'hA5, 8'h3C, 8'h0F, 0, 0, 4, 1'b0);
        run_word("stall", 8'hA5, 8'h3C, 8'h0F, 5, 0, 9, 1'b0);
        run_word("backpressure", 8'hA5, 8'h3C, 8'h0F, 0, 10, 4, 1'b0);

        // Reset in the middle of COLLECT, after one beat was taken.
        bus.out_ready = 1'b1;
        bus.in_data   = 8'hFF;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        check("midrst_collect_rnd_ready", 64'(bus.rnd_ready), 64'd1);
        bus.rnd       = 8'h11;
        bus.rnd_valid = 1'b1;
        tick();
        bus.rnd_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_rnd_ready", 64'(bus.rnd_ready), 64'd0);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_shares", 64'(bus.out_shares), 64'd0);
        rst = 1'b0;
        tick();
        run_word("after_midrst", 8'h00, 8'h22, 8'h44, 0, 0, 4, 1'b0);

        for (int w = 0; w < 4; w++) begin
            d  = 8'($urandom_range(0, 255));
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            run_word($sformatf("b2b%0d", w), d, b0, b1, 0, 0, 4, 1'b1);
        end
        bus.rnd_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
